// File: rtl/engine_arb_pkg.sv
// Shared types and defaults for the engine arbiter: FSM state encoding and
// default job shape.
package engine_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_CALC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_ITERS   = 4;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/engine_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester at or after ptr+1
// (mod NREQ) wins.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            valid_o,
    output logic [IDW-1:0]  idx_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                sum;

    // rot[0] lines up with requester ptr+1, so the lowest set bit is the winner
    assign dbl = {req_i, req_i} >> (int'(ptr_i) + 1);
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                sum     = int'(ptr_i) + 1 + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                idx_o = IDW'(sum);
            end
        end
    end

endmodule

// File: rtl/engine_arbiter.sv
// Shares one iterative engine among NREQ requesters: round-robin grant,
// ITERS start/calc/write passes per job, watchdog abort on a stuck pass.
module engine_arbiter
    import engine_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int ITERS   = DEF_ITERS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [$clog2(NREQ)-1:0]  cur_id,
    output logic                     busy,
    output logic                     ldx,
    output logic                     ldu,
    output logic                     eng_start,
    input  logic                     eng_done,
    output logic                     wr_req,
    output logic                     shl,
    output logic                     timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW  = $clog2(ITERS + 1);
    localparam int WW  = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0]   ITER_LAST = IW'(ITERS - 1);
    localparam logic [WW-1:0]   WDOG_LAST = WW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  PTR_INIT  = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE       = NREQ'(1);

    state_e          state_q, state_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            abort_q, abort_d;

    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] owner;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cur_id_q <= '0;
            ptr_q    <= PTR_INIT;
            iter_q   <= '0;
            wdog_q   <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            ptr_q    <= ptr_d;
            iter_q   <= iter_d;
            wdog_q   <= wdog_d;
            abort_q  <= abort_d;
        end
    end

    // eng_done matters only in CALC; a done on the last watchdog cycle still wins
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ptr_d    = ptr_q;
        iter_d   = iter_q;
        wdog_d   = wdog_q;
        abort_d  = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    cur_id_d = pick_idx;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                iter_d  = '0;
                state_d = ST_START;
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                if (eng_done) begin
                    state_d = ST_WRITE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                    if (wdog_q == WDOG_LAST) begin
                        abort_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                iter_d  = iter_q + IW'(1);
                state_d = (iter_q == ITER_LAST) ? ST_DONE : ST_START;
            end
            ST_DONE: begin
                ptr_d   = cur_id_q;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign owner       = ONE << cur_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign gnt         = busy ? owner : '0;
    assign done        = (state_q == ST_DONE) ? owner : '0;
    assign timeout_err = (state_q == ST_DONE) && abort_q;
    assign ldx         = (state_q == ST_GRANT);
    assign ldu         = (state_q == ST_GRANT);
    assign eng_start   = (state_q == ST_START);
    assign wr_req      = (state_q == ST_WRITE);
    assign shl         = (state_q == ST_WRITE);
    assign cur_id      = cur_id_q;

endmodule
